membus_arbiter: RTL and testbench

- Two-requester arbiter that shares one Membus slave port, such as the ACLINT/RAM decode path, between the instruction-fetch master (I) and the data/load-store master (D).
- Round-robin grant with at most one outstanding transaction.
- Requests are forwarded combinationally.
- Each response is routed back to the master that issued the request.
- Sits between the core and the memory-mapped slave decoder.

---
 rtl/membus_arbiter.sv | 151 +++++++++++++++
 tb/tb_membus_arbiter.sv | 298 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/membus_arbiter.sv
// Two-master (instruction fetch I, load/store D) round-robin arbiter onto one Membus slave port.
// Requests pass through combinationally; one transaction in flight, response routed to its issuer.
module membus_arbiter #(
    parameter int ADDR_WIDTH = 64,
    parameter int DATA_WIDTH = 64,
    parameter int MASK_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst,

    input  logic                  i_valid,
    output logic                  i_ready,
    input  logic [ADDR_WIDTH-1:0] i_addr,
    input  logic                  i_wen,
    input  logic [DATA_WIDTH-1:0] i_wdata,
    input  logic [MASK_WIDTH-1:0] i_wmask,
    output logic                  i_rvalid,
    output logic [DATA_WIDTH-1:0] i_rdata,

    input  logic                  d_valid,
    output logic                  d_ready,
    input  logic [ADDR_WIDTH-1:0] d_addr,
    input  logic                  d_wen,
    input  logic [DATA_WIDTH-1:0] d_wdata,
    input  logic [MASK_WIDTH-1:0] d_wmask,
    output logic                  d_rvalid,
    output logic [DATA_WIDTH-1:0] d_rdata,

    output logic                  s_valid,
    input  logic                  s_ready,
    output logic [ADDR_WIDTH-1:0] s_addr,
    output logic                  s_wen,
    output logic [DATA_WIDTH-1:0] s_wdata,
    output logic [MASK_WIDTH-1:0] s_wmask,
    input  logic                  s_rvalid,
    input  logic [DATA_WIDTH-1:0] s_rdata
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        WAIT_I = 2'd1,
        WAIT_D = 2'd2
    } owner_t;

    // Master encoding used by grant, last_grant and lock_sel: 0 = I, 1 = D.
    localparam logic SEL_I = 1'b0;
    localparam logic SEL_D = 1'b1;

    owner_t owner;
    owner_t owner_nxt;
    logic   last_grant;
    logic   lock;
    logic   lock_sel;

    logic   issue_ok;
    logic   grant;
    logic   req_vld;
    logic   accept;
    logic   stall;

    // A new request may launch while idle or in the cycle the outstanding response returns.
    assign issue_ok = rst & ((owner == IDLE) | s_rvalid);

    always_comb begin
        grant = ~last_grant;
        if (lock) begin
            grant = lock_sel;
        end else if (i_valid && !d_valid) begin
            grant = SEL_I;
        end else if (d_valid && !i_valid) begin
            grant = SEL_D;
        end
    end

    assign req_vld = (grant == SEL_D) ? d_valid : i_valid;
    assign s_valid = issue_ok & req_vld;
    assign accept  = s_valid & s_ready;
    assign stall   = s_valid & ~s_ready;

    always_comb begin
        s_addr  = '0;
        s_wen   = 1'b0;
        s_wdata = '0;
        s_wmask = '0;
        if (s_valid) begin
            if (grant == SEL_D) begin
                s_addr  = d_addr;
                s_wen   = d_wen;
                s_wdata = d_wdata;
                s_wmask = d_wmask;
            end else begin
                s_addr  = i_addr;
                s_wen   = i_wen;
                s_wdata = i_wdata;
                s_wmask = i_wmask;
            end
        end
    end

    assign i_ready = (grant == SEL_I) & issue_ok & s_ready & i_valid;
    assign d_ready = (grant == SEL_D) & issue_ok & s_ready & d_valid;

    // Owner FSM: state register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            owner <= IDLE;
        end else begin
            owner <= owner_nxt;
        end
    end

    // Owner FSM: next state. A response in IDLE is spurious and leaves the state alone.
    always_comb begin
        owner_nxt = owner;
        if (accept) begin
            owner_nxt = (grant == SEL_D) ? WAIT_D : WAIT_I;
        end else if (s_rvalid && (owner != IDLE)) begin
            owner_nxt = IDLE;
        end
    end

    // Owner FSM: outputs.
    always_comb begin
        i_rvalid = 1'b0;
        d_rvalid = 1'b0;
        case (owner)
            WAIT_I:  i_rvalid = s_rvalid;
            WAIT_D:  d_rvalid = s_rvalid;
            default: ;
        endcase
    end

    assign i_rdata = s_rdata;
    assign d_rdata = s_rdata;

    // A stalled request pins the grant so the slave never sees a request withdrawn.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            last_grant <= SEL_D;
            lock       <= 1'b0;
            lock_sel   <= SEL_I;
        end else if (accept) begin
            last_grant <= grant;
            lock       <= 1'b0;
        end else if (stall) begin
            lock       <= 1'b1;
            lock_sel   <= grant;
        end
    end

endmodule

// File: tb/tb_membus_arbiter.sv
// Self-checking bench for membus_arbiter: queued master requests, latency-programmable slave model,
// and a response scoreboard filled in expected grant order.
module tb_membus_arbiter;

    localparam logic [63:0] MMAP_ACLINT_MTIMECMP = 64'h0000_0000_0200_4000;

    logic        clk = 1'b0;
    logic        rst;
    logic        i_valid, i_ready, i_wen, i_rvalid;
    logic [63:0] i_addr, i_wdata, i_rdata;
    logic [7:0]  i_wmask;
    logic        d_valid, d_ready, d_wen, d_rvalid;
    logic [63:0] d_addr, d_wdata, d_rdata;
    logic [7:0]  d_wmask;
    logic        s_valid, s_ready, s_wen, s_rvalid;
    logic [63:0] s_addr, s_wdata, s_rdata;
    logic [7:0]  s_wmask;

    typedef struct {
        int          start;
        logic [63:0] addr;
        logic        wen;
        logic [63:0] wdata;
        logic [7:0]  wmask;
    } req_t;

    typedef struct {
        logic        m;
        logic [63:0] data;
    } exp_t;

    typedef struct {
        int          due;
        logic [63:0] data;
    } pend_t;

    req_t  i_q[$];
    req_t  d_q[$];
    exp_t  sb[$];
    pend_t pend[$];

    int   cyc = 0;
    int   n_tests = 0;
    int   n_fail = 0;
    int   lat = 1;
    logic sready_next = 1'b0;
    logic drop_resp = 1'b0;
    logic inject = 1'b0;

    membus_arbiter #(
        .ADDR_WIDTH(64),
        .DATA_WIDTH(64),
        .MASK_WIDTH(8)
    ) dut (
        .clk(clk), .rst(rst),
        .i_valid(i_valid), .i_ready(i_ready), .i_addr(i_addr), .i_wen(i_wen),
        .i_wdata(i_wdata), .i_wmask(i_wmask), .i_rvalid(i_rvalid), .i_rdata(i_rdata),
        .d_valid(d_valid), .d_ready(d_ready), .d_addr(d_addr), .d_wen(d_wen),
        .d_wdata(d_wdata), .d_wmask(d_wmask), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
        .s_valid(s_valid), .s_ready(s_ready), .s_addr(s_addr), .s_wen(s_wen),
        .s_wdata(s_wdata), .s_wmask(s_wmask), .s_rvalid(s_rvalid), .s_rdata(s_rdata)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got %h expected %h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    function automatic logic [63:0] rsp_fn(input logic [63:0] a);
        return (a == 64'h1000) ? 64'hDEAD_BEEF : {a[31:0] ^ 32'h5A5A_5A5A, ~a[31:0]};
    endfunction

    // Queue a request for master m (0 = I, 1 = D); when a response is due, record it in grant order.
    task automatic req(input logic m, input int start, input logic [63:0] addr, input logic wen,
                       input logic [63:0] wdata, input logic [7:0] wmask, input logic expect_rsp);
        req_t r;
        r.start = start; r.addr = addr; r.wen = wen; r.wdata = wdata; r.wmask = wmask;
        if (m) d_q.push_back(r);
        else   i_q.push_back(r);
        if (expect_rsp) sb.push_back('{m: m, data: rsp_fn(addr)});
    endtask

    task automatic drain(input int max_cycles);
        for (int n = 0; n < max_cycles; n++) begin
            if (sb.size() == 0 && i_q.size() == 0 && d_q.size() == 0 && pend.size() == 0) break;
            @(negedge clk);
        end
        chk("drain_sb", 64'(sb.size()), 64'd0);
        @(negedge clk);
    endtask

    task automatic reset_pulse();
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
    endtask

    // Master drivers: present the head request once its start cycle arrives, hold until ready.
    initial begin
        i_valid = 0; i_addr = '0; i_wen = 0; i_wdata = '0; i_wmask = '0;
        d_valid = 0; d_addr = '0; d_wen = 0; d_wdata = '0; d_wmask = '0;
        s_ready = 0;
        forever begin
            @(posedge clk);
            #1;
            s_ready = sready_next;
            if (i_q.size() > 0 && i_q[0].start <= cyc) begin
                i_valid = 1; i_addr = i_q[0].addr; i_wen = i_q[0].wen;
                i_wdata = i_q[0].wdata; i_wmask = i_q[0].wmask;
            end else begin
                i_valid = 0; i_addr = '0; i_wen = 0; i_wdata = '0; i_wmask = '0;
            end
            if (d_q.size() > 0 && d_q[0].start <= cyc) begin
                d_valid = 1; d_addr = d_q[0].addr; d_wen = d_q[0].wen;
                d_wdata = d_q[0].wdata; d_wmask = d_q[0].wmask;
            end else begin
                d_valid = 0; d_addr = '0; d_wen = 0; d_wdata = '0; d_wmask = '0;
            end
        end
    end

    // Slave model: responds lat cycles after acceptance; inject forces a stray response.
    initial begin
        s_rvalid = 0;
        s_rdata  = '0;
        forever begin
            @(posedge clk);
            #2;
            if (pend.size() > 0 && pend[0].due == cyc) begin
                s_rvalid = 1;
                s_rdata  = pend[0].data;
                void'(pend.pop_front());
            end else begin
                s_rvalid = inject;
                s_rdata  = inject ? 64'hBAD0_BAD0_BAD0_BAD0 : '0;
            end
        end
    end

    // Handshake and response monitor.
    always @(negedge clk) begin
        exp_t e;
        if (s_valid && s_ready && !drop_resp)
            pend.push_back('{due: cyc + lat, data: rsp_fn(s_addr)});
        if (i_ready && i_q.size() > 0) void'(i_q.pop_front());
        if (d_ready && d_q.size() > 0) void'(d_q.pop_front());
        if (i_rvalid || d_rvalid) begin
            if (sb.size() == 0) begin
                chk("rsp_unexpected", {62'd0, i_rvalid, d_rvalid}, 64'd0);
            end else begin
                e = sb.pop_front();
                chk("rsp_onehot", 64'(i_rvalid & d_rvalid), 64'd0);
                chk("rsp_master", 64'(d_rvalid), 64'(e.m));
                chk("rsp_data", d_rvalid ? d_rdata : i_rdata, e.data);
            end
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int base;
        rst = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_s_valid", 64'(s_valid), 64'd0);
        chk("rst_i_ready", 64'(i_ready), 64'd0);
        chk("rst_d_ready", 64'(d_ready), 64'd0);
        chk("rst_i_rvalid", 64'(i_rvalid), 64'd0);
        chk("rst_d_rvalid", 64'(d_rvalid), 64'd0);
        rst = 1'b1;
        @(negedge clk);
        chk("idle_s_addr", s_addr, 64'd0);

        // Single I read.
        sready_next = 1; lat = 1;
        req(1'b0, cyc + 1, 64'h1000, 1'b0, '0, '0, 1'b1);
        @(negedge clk);
        chk("t1_i_ready", 64'(i_ready), 64'd1);
        chk("t1_d_ready", 64'(d_ready), 64'd0);
        chk("t1_s_addr", s_addr, 64'h1000);
        chk("t1_s_wen", 64'(s_wen), 64'd0);
        @(negedge clk);
        chk("t1_i_rvalid", 64'(i_rvalid), 64'd1);
        chk("t1_i_rdata", i_rdata, 64'hDEAD_BEEF);
        chk("t1_d_rvalid", 64'(d_rvalid), 64'd0);
        drain(10);

        // Both masters busy from reset: strict I/D alternation at one per cycle.
        reset_pulse();
        base = cyc + 1;
        for (int k = 0; k < 3; k++) begin
            req(1'b0, base, 64'h2000 + 64'(k * 8), 1'b0, '0, '0, 1'b1);
            req(1'b1, base, 64'h3000 + 64'(k * 8), 1'b0, '0, '0, 1'b1);
        end
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            chk("t2_s_addr", s_addr, ((k % 2) != 0 ? 64'h3000 : 64'h2000) + 64'((k / 2) * 8));
            chk("t2_i_ready", 64'(i_ready), 64'((k % 2) == 0));
            chk("t2_d_ready", 64'(d_ready), 64'((k % 2) != 0));
        end
        drain(20);

        // Stalled D request keeps the grant while I arrives.
        sready_next = 0;
        base = cyc + 1;
        req(1'b1, base, 64'h4000, 1'b0, '0, '0, 1'b1);
        req(1'b0, base + 1, 64'h5000, 1'b0, '0, '0, 1'b1);
        for (int j = 0; j < 3; j++) begin
            @(negedge clk);
            chk("t3_s_valid", 64'(s_valid), 64'd1);
            chk("t3_s_addr", s_addr, 64'h4000);
            chk("t3_d_ready", 64'(d_ready), 64'd0);
            chk("t3_i_ready", 64'(i_ready), 64'd0);
            if (j == 2) sready_next = 1;
        end
        @(negedge clk);
        chk("t3_d_accept", 64'(d_ready), 64'd1);
        chk("t3_d_addr", s_addr, 64'h4000);
        @(negedge clk);
        chk("t3_i_accept", 64'(i_ready), 64'd1);
        chk("t3_i_addr", s_addr, 64'h5000);
        drain(20);

        // Slow slave: D waits until the I response cycle, then goes out back-to-back.
        lat = 5;
        base = cyc + 1;
        req(1'b0, base, 64'h6000, 1'b0, '0, '0, 1'b1);
        req(1'b1, base + 1, 64'h7000, 1'b0, '0, '0, 1'b1);
        @(negedge clk);
        chk("t4_i_ready", 64'(i_ready), 64'd1);
        for (int j = 1; j < 5; j++) begin
            @(negedge clk);
            lat = 1;
            chk("t4_wait_s_valid", 64'(s_valid), 64'd0);
            chk("t4_wait_d_ready", 64'(d_ready), 64'd0);
            chk("t4_wait_s_addr", s_addr, 64'd0);
        end
        @(negedge clk);
        chk("t4_i_rvalid", 64'(i_rvalid), 64'd1);
        chk("t4_d_ready", 64'(d_ready), 64'd1);
        chk("t4_s_addr", s_addr, 64'h7000);
        drain(20);

        // D write to the ACLINT compare register.
        req(1'b1, cyc + 1, MMAP_ACLINT_MTIMECMP, 1'b1, 64'h1234, 8'h0F, 1'b1);
        @(negedge clk);
        chk("t5_d_ready", 64'(d_ready), 64'd1);
        chk("t5_s_addr", s_addr, MMAP_ACLINT_MTIMECMP);
        chk("t5_s_wen", 64'(s_wen), 64'd1);
        chk("t5_s_wdata", s_wdata, 64'h1234);
        chk("t5_s_wmask", 64'(s_wmask), 64'h0F);
        @(negedge clk);
        chk("t5_d_rvalid", 64'(d_rvalid), 64'd1);
        chk("t5_i_rvalid", 64'(i_rvalid), 64'd0);
        drain(10);

        // Reset while D is outstanding; the late response must be dropped.
        drop_resp = 1;
        req(1'b1, cyc + 1, 64'h8000, 1'b0, '0, '0, 1'b0);
        @(negedge clk);
        chk("t6_d_ready", 64'(d_ready), 64'd1);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("t6_rst_s_valid", 64'(s_valid), 64'd0);
        chk("t6_rst_d_rvalid", 64'(d_rvalid), 64'd0);
        rst = 1'b1;
        drop_resp = 0;
        inject = 1;
        @(negedge clk);
        chk("t6_stray_s_rvalid", 64'(s_rvalid), 64'd1);
        chk("t6_stray_d_rvalid", 64'(d_rvalid), 64'd0);
        chk("t6_stray_i_rvalid", 64'(i_rvalid), 64'd0);
        inject = 0;
        req(1'b0, cyc + 1, 64'h9000, 1'b0, '0, '0, 1'b1);
        @(negedge clk);
        chk("t6_i_ready", 64'(i_ready), 64'd1);
        chk("t6_s_addr", s_addr, 64'h9000);
        drain(10);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
